qbus_iack: RTL
==============

QBUS_IACK -- requirements
Module: qbus_iack

Interface
REQ-001 Parameter RPLY_DLY, default 2: number of clk_i cycles the vector is driven before rply_o asserts. Legal range 1..15.
REQ-002 clk_i  in  1  single system clock; all logic is on the rising edge.
REQ-003 rst_i  in  1  reset; synchronous and active-low.
REQ-004 irq_i  in  1  this device's pending interrupt request, i.e. the bus_int irq_o output.
REQ-005 vec_i  in  9  interrupt vector; bits 1:0 are ignored.
REQ-006 din_i  in  1  bus DIN, active-high, asynchronous to clk_i.
REQ-007 iaki_i  in  1  interrupt-acknowledge daisy-chain input, active-high, asynchronous to clk_i.
REQ-008 iako_o  out  1  daisy-chain output to the downstream device.
REQ-009 rply_o  out  1  bus RPLY for the vector transfer.
REQ-010 dal_o  out  16  vector data: {7'b0, captured vec[8:2], 2'b00}.
REQ-011 dal_oe_o  out  1  DAL output enable.
REQ-012 ack_o  out  1  one-cycle pulse to bus_int ack_i when the vector transfer is granted.

Function
REQ-013 din_i and iaki_i SHALL each pass a 2-flop synchronizer; the FSM uses only the synchronized values din_s and iaki_s.
REQ-014 The FSM SHALL have states IDLE, ARM, PASS, DRIVE and REPLY, plus a flag mine and a 4-bit delay counter.
REQ-015 IDLE: when din_s=1, SHALL go to ARM and capture mine <= irq_i.
REQ-016 ARM:
- din_s=0: SHALL go to IDLE (plain DATI cycle, no IAK).
- iaki_s=1 and (mine & irq_i)=1: SHALL go to DRIVE.
- iaki_s=1 otherwise: SHALL go to PASS.
REQ-017 A request that rises after the ARM capture SHALL NOT be served in the current cycle; the grant SHALL be passed.
REQ-018 PASS: iako_o SHALL be 1 in this state only; when din_s=0 or iaki_s=0, SHALL go to IDLE.
REQ-019 Entry to DRIVE:
- ack_o SHALL pulse for exactly one cycle.
- vec_i[8:2] SHALL be latched.
- the delay counter SHALL load RPLY_DLY-1.
REQ-020 DRIVE: dal_oe_o SHALL be 1 and the counter SHALL decrement; at 0, SHALL go to REPLY.
REQ-021 REPLY: rply_o=1 and dal_oe_o=1; when din_s=0, SHALL go to IDLE, and rply_o and dal_oe_o SHALL read 0 on the next cycle.
REQ-022 If din_s falls during DRIVE, the FSM SHALL go to IDLE immediately; rply_o SHALL never assert.
REQ-023 iaki_s falling during DRIVE or REPLY SHALL be ignored.
REQ-024 iako_o SHALL never be 1 while dal_oe_o or rply_o is 1.
REQ-025 ack_o SHALL pulse at most once per DIN assertion.
REQ-026 din_s and iaki_s rising on the same cycle: one ARM cycle SHALL be taken before the grant decision.
REQ-027 Latency: from the iaki_i rise, with din_s already 1, DRIVE SHALL be entered at cycle 3; rply_o SHALL assert RPLY_DLY cycles later.
REQ-028 While dal_oe_o=0, dal_o SHALL read 16'h0000.

Reset
REQ-029 With rst_i=0 at a clock edge, the block SHALL go to IDLE and clear mine, the counter and the synchronizer flops.
REQ-030 During reset, iako_o, rply_o, dal_oe_o and ack_o SHALL be 0, and dal_o SHALL be 16'h0000.
REQ-031 Reset asserted mid-transfer SHALL drop rply_o and dal_oe_o at that clock edge, with no ack_o pulse.

Structure
REQ-032 FSM state encodings and the DAL vector-format constants SHALL live in the shared bus definitions include (qbus_defs).
REQ-033 The 2-flop synchronizer SHALL be a separate sub-module, bus_sync, instantiated twice.

Verification (RPLY_DLY=2, vec_i=9'o300)
REQ-034 Grant and reply:
- Stimulus: irq_i=1, din_i rises, then iaki_i rises.
- Response: ack_o pulses once; dal_o=16'h00C0 with dal_oe_o=1; rply_o rises 2 cycles after DRIVE entry; after din_i falls, rply_o and dal_oe_o are 0 within 3 cycles.
REQ-035 No request:
- Stimulus: irq_i=0, din_i then iaki_i rise.
- Response: iako_o follows iaki_i; no ack_o pulse; dal_oe_o stays 0.
REQ-036 Late request:
- Stimulus: irq_i rises one cycle after ARM entry, then iaki_i rises.
- Response: the grant is passed (iako_o=1); no ack_o pulse.
REQ-037 Plain DATI:
- Stimulus: din_i pulses 6 cycles with iaki_i=0.
- Response: return to IDLE; all outputs stay 0.
REQ-038 DIN abort:
- Stimulus: din_i falls one cycle into DRIVE.
- Response: rply_o never asserts; dal_oe_o is 0 next cycle; ack_o pulsed exactly once.
REQ-039 Reset mid-transfer:
- Stimulus: rst_i=0 during REPLY.
- Response: rply_o=0 and dal_oe_o=0 at that edge; the next DIN assertion operates normally.

Source files
------------

// File: rtl/qbus_defs.sv
// Shared Q-bus definitions: IAK state encodings and the DAL vector word format.
package qbus_defs;

  localparam int unsigned DAL_W       = 16;
  localparam int unsigned VEC_W       = 9;
  localparam int unsigned VEC_HI      = 8;
  localparam int unsigned VEC_LO      = 2;
  localparam int unsigned VEC_FIELD_W = VEC_HI - VEC_LO + 1;
  localparam int unsigned DAL_PAD_W   = DAL_W - VEC_FIELD_W - VEC_LO;
  localparam int unsigned DLY_CNT_W   = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    PASS  = 3'd2,
    DRIVE = 3'd3,
    REPLY = 3'd4
  } iack_state_e;

  // Vector word as it appears on DAL during the IAK transfer
  typedef struct packed {
    logic [DAL_PAD_W-1:0]   pad;
    logic [VEC_FIELD_W-1:0] vec;
    logic [VEC_LO-1:0]      lo;
  } dal_vec_t;

  function automatic logic [DAL_W-1:0] fmt_dal(input logic [VEC_FIELD_W-1:0] v);
    dal_vec_t d;
    d.pad = '0;
    d.vec = v;
    d.lo  = '0;
    return d;
  endfunction

endpackage

// File: rtl/bus_sync.sv
// Two-flop synchronizer for a single asynchronous bus control line.
module bus_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/qbus_iack.sv
// Q-bus interrupt-acknowledge responder: vector transfer or daisy-chain pass-through.
module qbus_iack
  import qbus_defs::*;
#(
  parameter int unsigned RPLY_DLY = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                irq_i,
  input  logic [VEC_W-1:0]    vec_i,
  input  logic                din_i,
  input  logic                iaki_i,
  output logic                iako_o,
  output logic                rply_o,
  output logic [DAL_W-1:0]    dal_o,
  output logic                dal_oe_o,
  output logic                ack_o
);

  logic                 din_s;
  logic                 iaki_s;
  iack_state_e          state, state_n;
  logic                 mine, mine_n;
  logic [DLY_CNT_W-1:0] cnt, cnt_n;
  logic [DAL_W-1:0]     dal_n;
  logic                 iako_n, rply_n, oe_n, ack_n;
  logic                 unused_vec_lsbs;

  assign unused_vec_lsbs = ^vec_i[VEC_LO-1:0];

  bus_sync u_din_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d     (din_i),
    .q     (din_s)
  );

  bus_sync u_iaki_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d     (iaki_i),
    .q     (iaki_s)
  );

  // State, flag, counter and output registers
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      mine     <= 1'b0;
      cnt      <= '0;
      iako_o   <= 1'b0;
      rply_o   <= 1'b0;
      dal_oe_o <= 1'b0;
      ack_o    <= 1'b0;
      dal_o    <= '0;
    end else begin
      state    <= state_n;
      mine     <= mine_n;
      cnt      <= cnt_n;
      iako_o   <= iako_n;
      rply_o   <= rply_n;
      dal_oe_o <= oe_n;
      ack_o    <= ack_n;
      dal_o    <= dal_n;
    end
  end

  // Next state; outputs are decoded from the next state so they align with it
  always_comb begin
    state_n = state;
    mine_n  = mine;
    cnt_n   = cnt;
    dal_n   = dal_o;
    ack_n   = 1'b0;
    iako_n  = 1'b0;
    rply_n  = 1'b0;
    oe_n    = 1'b0;

    case (state)
      IDLE: begin
        if (din_s) begin
          state_n = ARM;
          mine_n  = irq_i;
        end
      end
      ARM: begin
        if (!din_s) begin
          state_n = IDLE;
        end else if (iaki_s) begin
          // Only a request already pending at DIN time may claim the grant
          if (mine && irq_i) begin
            state_n = DRIVE;
            ack_n   = 1'b1;
            cnt_n   = DLY_CNT_W'(RPLY_DLY - 1);
            dal_n   = fmt_dal(vec_i[VEC_HI:VEC_LO]);
          end else begin
            state_n = PASS;
          end
        end
      end
      PASS: begin
        if (!din_s || !iaki_s) state_n = IDLE;
      end
      DRIVE: begin
        if (!din_s) begin
          state_n = IDLE;
        end else if (cnt == '0) begin
          state_n = REPLY;
        end else begin
          cnt_n = cnt - DLY_CNT_W'(1);
        end
      end
      REPLY: begin
        if (!din_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    iako_n = (state_n == PASS);
    oe_n   = (state_n == DRIVE) || (state_n == REPLY);
    rply_n = (state_n == REPLY);
    if (!oe_n) dal_n = '0;
  end

endmodule
